// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle IEEE-754 single add/sub sequencer driving an external 24-bit mantissa adder.
// Truncating, flush-to-zero; define FP_SPECIAL_EN to short-circuit Inf/NaN operands.
module fp_addsub_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [23:0] adder_a,
    output logic [23:0] adder_b,
    output logic        adder_op,
    input  logic [23:0] adder_result,
    input  logic        adder_cout
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state;
    logic [23:0] x_q, y_q, m_q;
    logic [7:0]  d_q;
    logic [8:0]  exp_q;
    logic        sign_q, eff_sub_q, ovf_q;

    logic [7:0]  exp_a, exp_b;
    logic [23:0] man_a, man_b;
    logic        sign_a, sign_b, a_is_x;
    logic [8:0]  exp_inc;

    // exp == 0 (zero or denormal) contributes a zero mantissa, so ordering on
    // {exp, mantissa} picks the larger magnitude directly.
    assign exp_a   = a[30:23];
    assign exp_b   = b[30:23];
    assign man_a   = (exp_a != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
    assign man_b   = (exp_b != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
    assign sign_a  = a[31];
    assign sign_b  = b[31] ^ sub;
    assign a_is_x  = {exp_a, man_a} >= {exp_b, man_b};
    assign exp_inc = exp_q + 9'd1;

    assign adder_a  = x_q;
    assign adder_b  = y_q;
    assign adder_op = eff_sub_q;

`ifdef FP_SPECIAL_EN
    logic        special;
    logic [31:0] special_res;
    logic        inf_a, inf_b, nan_a, nan_b;

    always_comb begin
        inf_a   = (exp_a == 8'hFF) && (a[22:0] == 23'd0);
        inf_b   = (exp_b == 8'hFF) && (b[22:0] == 23'd0);
        nan_a   = (exp_a == 8'hFF) && (a[22:0] != 23'd0);
        nan_b   = (exp_b == 8'hFF) && (b[22:0] != 23'd0);
        special = (exp_a == 8'hFF) || (exp_b == 8'hFF);
        if (nan_a || nan_b || (inf_a && inf_b && (sign_a ^ sign_b)))
            special_res = 32'h7FC0_0000;
        else if (inf_a)
            special_res = {sign_a, 8'hFF, 23'd0};
        else
            special_res = {sign_b, 8'hFF, 23'd0};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 32'd0;
            x_q       <= 24'd0;
            y_q       <= 24'd0;
            m_q       <= 24'd0;
            d_q       <= 8'd0;
            exp_q     <= 9'd0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle; only the branches entering DONE raise it.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef FP_SPECIAL_EN
                        if (special) begin
                            result <= special_res;
                            done   <= 1'b1;
                            busy   <= 1'b1;
                            state  <= DONE;
                        end else
`endif
                        begin
                            x_q       <= a_is_x ? man_a : man_b;
                            y_q       <= a_is_x ? man_b : man_a;
                            exp_q     <= {1'b0, (a_is_x ? exp_a : exp_b)};
                            d_q       <= a_is_x ? (exp_a - exp_b) : (exp_b - exp_a);
                            sign_q    <= a_is_x ? sign_a : sign_b;
                            eff_sub_q <= sign_a ^ sign_b;
                            busy      <= 1'b1;
                            state     <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (d_q == 8'd0) begin
                        state <= ADD;
                    end else if (d_q >= 8'd24) begin
                        y_q <= 24'd0;
                        d_q <= 8'd0;
                    end else begin
                        y_q <= y_q >> 1;
                        d_q <= d_q - 8'd1;
                    end
                end
                ADD: begin
                    m_q   <= adder_result;
                    ovf_q <= adder_cout & ~eff_sub_q;
                    state <= NORM;
                end
                NORM: begin
                    if (ovf_q) begin
                        if (exp_inc >= 9'd255)
                            result <= {sign_q, 8'hFF, 23'd0};
                        else
                            result <= {sign_q, exp_inc[7:0], m_q[23:1]};
                        m_q   <= {1'b1, m_q[23:1]};
                        exp_q <= exp_inc;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (m_q == 24'd0) begin
                        result <= 32'd0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (m_q[23]) begin
                        result <= {sign_q, exp_q[7:0], m_q[22:0]};
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (exp_q == 9'd1) begin
                        result <= 32'd0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        m_q   <= {m_q[22:0], 1'b0};
                        exp_q <= exp_q - 9'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Scoreboard bench for fp_addsub_sequencer: directed vectors, reset abort, random ops vs a reference model.
module tb_fp_addsub_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, sub;
    logic [31:0] a, b;
    logic        busy, done, adder_op, adder_cout;
    logic [31:0] result;
    logic [23:0] adder_a, adder_b, adder_result;
    logic [24:0] add_sum;

    fp_addsub_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
        .busy(busy), .done(done), .result(result),
        .adder_a(adder_a), .adder_b(adder_b), .adder_op(adder_op),
        .adder_result(adder_result), .adder_cout(adder_cout)
    );

    // Behavioural stand-in for the shared ripple adder/subtractor.
    assign add_sum      = adder_op ? ({1'b0, adder_a} + {1'b0, ~adder_b} + 25'd1)
                                   : ({1'b0, adder_a} + {1'b0, adder_b});
    assign adder_result = add_sum[23:0];
    assign adder_cout   = add_sum[24];

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic void fp_model(input logic [31:0] fa, input logic [31:0] fb, input logic fs,
                                     output logic [31:0] r, output int lat);
        int ea, eb, ma, mb, ex, ey, mx, my, m, e, d, al, sh;
        logic sa, sb, sx, sy;
        ea = int'(fa[30:23]);
        eb = int'(fb[30:23]);
        ma = (ea != 0) ? ((1 << 23) | int'(fa[22:0])) : 0;
        mb = (eb != 0) ? ((1 << 23) | int'(fb[22:0])) : 0;
        sa = fa[31];
        sb = fb[31] ^ fs;
        if (ea > eb || (ea == eb && ma >= mb)) begin
            ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
        end else begin
            ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
        end
        d = ex - ey;
        if (d >= 24) begin my = 0; al = 1; end
        else begin my = my >> d; al = d; end
        m  = (sx ^ sy) ? (mx - my) : (mx + my);
        e  = ex;
        sh = 0;
        if (m >= (1 << 24)) begin
            m = m >> 1;
            e = e + 1;
            r = (e >= 255) ? {sx, 8'hFF, 23'd0} : {sx, e[7:0], m[22:0]};
        end else if (m == 0) begin
            r = 32'd0;
        end else begin
            while (m < (1 << 23) && e != 1) begin
                m = m << 1;
                e = e - 1;
                sh++;
            end
            r = (m < (1 << 23)) ? 32'd0 : {sx, e[7:0], m[22:0]};
        end
        lat = 3 + al + sh;
    endfunction

    // Result checker: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.tag, result, e.res);
            end
        end
    end

    // normal=1: the operation goes through ALIGN/ADD/NORM, so latency and adder_op are checked.
    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic is, input logic [31:0] er, input int el,
                          input bit normal, input bit poke);
        int cnt;
        exp_t e;
        e.res = er;
        e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        a = ia; b = ib; sub = is; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (normal)
            check({tag, "_adder_op"}, 32'(adder_op), 32'(ia[31] ^ ib[31] ^ is));
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (poke && cnt == 1) begin
                a = 32'h4040_0000; b = 32'hC000_0000; sub = 1'b1; start = 1'b1;
            end
            if (poke && cnt == 2) start = 1'b0;
        end
        if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
        if (normal) check({tag, "_latency"}, cnt, el);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_busy_clear"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, result, er);
    endtask

    initial begin
        logic [31:0] ra, rb, rr;
        logic        rs;
        int          rl, ea, eb;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 32'd0; b = 32'd0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_adder_a", 32'(adder_a), 32'd0);
        check("rst_adder_b", 32'(adder_b), 32'd0);
        check("rst_adder_op", 32'(adder_op), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("one_plus_one",  32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3, 1, 0);
        run_op("one_minus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3, 1, 0);
        run_op("align_d2",      32'h3FC0_0000, 32'h3E80_0000, 1'b0, 32'h3FE0_0000, 5, 1, 0);
        run_op("norm_2shift",   32'h3F80_0000, 32'h3F40_0000, 1'b1, 32'h3E80_0000, 6, 1, 0);
        run_op("start_busy",    32'h3FC0_0000, 32'h3E80_0000, 1'b0, 32'h3FE0_0000, 5, 1, 1);

        // Abort in NORM: start edge, two ALIGN cycles, ADD, then NORM.
        @(negedge clk);
        a = 32'h3F80_0000; b = 32'h3F40_0000; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_adder_a", 32'(adder_a), 32'd0);
        check("abort_adder_b", 32'(adder_b), 32'd0);
        check("abort_adder_op", 32'(adder_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        run_op("post_reset",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3, 1, 0);
        run_op("align_d24",     32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4, 1, 0);
        run_op("align_d23",     32'h3F80_0000, 32'h3400_0000, 1'b0, 32'h3F80_0001, 26, 1, 0);
        run_op("denorm_in",     32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 4, 1, 0);
        run_op("flush_out",     32'h0100_0000, 32'h00C0_0000, 1'b1, 32'h0000_0000, 5, 1, 0);
        run_op("swap_neg",      32'h3F40_0000, 32'h3F80_0000, 1'b1, 32'hBE80_0000, 6, 1, 0);
        run_op("ovf_to_inf",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3, 1, 0);
`ifdef FP_SPECIAL_EN
        run_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 0, 0, 0);
        run_op("inf_plus_one",  32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 0, 0, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            ea = int'($urandom_range(1, 254));
            eb = ea + int'($urandom_range(0, 60)) - 30;
            if (eb < 0) eb = 0;
            if (eb > 254) eb = 254;
            ra = {1'($urandom_range(0, 1)), ea[7:0], 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), eb[7:0], 23'($urandom)};
            if (i % 10 == 3) rb = ra;
            rs = 1'($urandom_range(0, 1));
            fp_model(ra, rb, rs, rr, rl);
            run_op($sformatf("rand%0d", i), ra, rb, rs, rr, rl, 1, 0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
